// File: rtl/cpu_pkg.sv
// Shared decode constants and hazard FSM state type for the core pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  // Primary opcodes, ir[31:27]
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // R-type ALU ops, ir[6:2]
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [4:0] ZERO_REG   = 5'd0;
  localparam logic [4:0] STATUS_REG = 5'd30;

  typedef enum logic {
    IDLE   = 1'b0,
    MD_RUN = 1'b1
  } hz_state_e;

  function automatic logic is_muldiv(input logic [31:0] ir);
    return (ir[31:27] == OP_RTYPE) && ((ir[6:2] == ALU_MUL) || (ir[6:2] == ALU_DIV));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the pipeline latches and the hazard/stall controller.
// Latency: n/a (wires only).
// Backpressure: n/a; pc_we/fd_we/dx_we are the stall controls themselves.
// master = pipeline side (drives instructions/status), slave = controller.
interface hazard_stall_ctrl_if;
  logic [31:0] fd_ir;
  logic [31:0] dx_ir;
  logic        branch_taken;
  logic        md_ready;
  logic        md_exception;
  logic        pc_we;
  logic        fd_we;
  logic        dx_we;
  logic        fd_flush;
  logic        dx_nop;
  logic        xm_nop;
  logic        md_start;
  logic        md_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output fd_ir, dx_ir, branch_taken, md_ready, md_exception,
    input  pc_we, fd_we, dx_we, fd_flush, dx_nop, xm_nop, md_start, md_err,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  fd_ir, dx_ir, branch_taken, md_ready, md_exception,
    output pc_we, fd_we, dx_we, fd_flush, dx_nop, xm_nop, md_start, md_err,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/src_reg_decode.sv
// Maps an instruction to its two source register indices plus a valid mask.
// Latency: combinational, 0 cycles.
// Backpressure: none.
// Ports: i_ir instruction; o_src0/o_src1 indices; o_vld[1:0] per-source valid;
// o_src1_st_data marks src1 as sw store data (late-consumed, forwardable in M).
module src_reg_decode #(
  parameter logic [4:0] STATUS_REG = cpu_pkg::STATUS_REG
) (
  input  logic [31:0] i_ir,
  output logic [4:0]  o_src0,
  output logic [4:0]  o_src1,
  output logic [1:0]  o_vld,
  output logic        o_src1_st_data
);
  import cpu_pkg::*;

  logic [4:0] w_op;
  logic       w_unused_ir;

  assign w_op        = i_ir[31:27];
  assign w_unused_ir = ^i_ir[11:0];

  always_comb begin
    o_src0         = i_ir[21:17];
    o_src1         = 5'd0;
    o_vld          = 2'b01;
    o_src1_st_data = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        o_src1 = i_ir[16:12];
        o_vld  = 2'b11;
      end
      OP_SW, OP_BNE, OP_BLT: begin
        // These read the rd field as a second operand.
        o_src1         = i_ir[26:22];
        o_vld          = 2'b11;
        o_src1_st_data = (w_op == OP_SW);
      end
      OP_JR:   o_src0 = i_ir[26:22];
      OP_BEX:  o_src0 = STATUS_REG;
      default: ;
    endcase
  end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: load-use bubbles, mul/div occupancy, branch squash.
// Latency: outputs combinational from current state and F/D, D/X instructions.
// Backpressure: holds PC/F/D/D/X via write enables while mul/div runs or on load-use.
// Ports: clock, reset (sync, active-high), bus (slave modport of hazard_stall_ctrl_if).
// Build option HAZARD_PERF_EN adds stall/flush cycle counters; otherwise they read 0.
module hazard_stall_ctrl #(
  parameter int         MD_WATCHDOG = 64,
  parameter logic [4:0] ZERO_REG    = cpu_pkg::ZERO_REG,
  parameter logic [4:0] STATUS_REG  = cpu_pkg::STATUS_REG
) (
  input logic               clock,
  input logic               reset,
  hazard_stall_ctrl_if.slave bus
);
  import cpu_pkg::*;

  localparam int WD_W = (MD_WATCHDOG < 128) ? 7 : $clog2(MD_WATCHDOG + 1);
  // Counter reads k-1 in the k-th MD_RUN cycle, so abort lands MD_WATCHDOG cycles after md_start.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_WATCHDOG - 1);

  hz_state_e       r_state;
  hz_state_e       w_state_nxt;
  logic [WD_W-1:0] r_wd_cnt;

  logic [4:0] w_src0;
  logic [4:0] w_src1;
  logic [1:0] w_src_vld;
  logic       w_src1_st_data;
  logic [4:0] w_dx_rd;
  logic       w_dx_is_lw;
  logic       w_dx_md;
  logic       w_load_use;
  logic       w_wd_fire;
  logic       w_unused;

  src_reg_decode #(.STATUS_REG(STATUS_REG)) u_fd_dec (
    .i_ir           (bus.fd_ir),
    .o_src0         (w_src0),
    .o_src1         (w_src1),
    .o_vld          (w_src_vld),
    .o_src1_st_data (w_src1_st_data)
  );

  assign w_dx_rd    = bus.dx_ir[26:22];
  assign w_dx_is_lw = (bus.dx_ir[31:27] == OP_LW);
  assign w_dx_md    = is_muldiv(bus.dx_ir);
  assign w_unused   = ^{bus.md_exception, bus.dx_ir[21:7], bus.dx_ir[1:0]};

  // sw data can be forwarded from M/W, so a match only on it is not a hazard.
  assign w_load_use = w_dx_is_lw && (w_dx_rd != ZERO_REG) &&
                      ((w_src_vld[0] && (w_src0 == w_dx_rd)) ||
                       (w_src_vld[1] && !w_src1_st_data && (w_src1 == w_dx_rd)));

  assign w_wd_fire = (MD_WATCHDOG != 0) && (r_wd_cnt == WD_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    bus.pc_we    = 1'b1;
    bus.fd_we    = 1'b1;
    bus.dx_we    = 1'b1;
    bus.fd_flush = 1'b0;
    bus.dx_nop   = 1'b0;
    bus.xm_nop   = 1'b0;
    bus.md_start = 1'b0;
    bus.md_err   = 1'b0;
    if (reset) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dx_md) begin
            bus.md_start = 1'b1;
            bus.pc_we    = 1'b0;
            bus.fd_we    = 1'b0;
            bus.dx_we    = 1'b0;
            bus.xm_nop   = 1'b1;
            w_state_nxt  = MD_RUN;
          end else if (bus.branch_taken) begin
            // Squashes the F/D instruction, so any load-use on it is moot.
            bus.fd_flush = 1'b1;
            bus.dx_nop   = 1'b1;
          end else if (w_load_use) begin
            bus.pc_we  = 1'b0;
            bus.fd_we  = 1'b0;
            bus.dx_nop = 1'b1;
          end
        end
        MD_RUN: begin
          if (bus.md_ready) begin
            // Zero-bubble release: result moves on in the same cycle.
            w_state_nxt = IDLE;
          end else if (w_wd_fire) begin
            bus.md_err  = 1'b1;
            bus.xm_nop  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            bus.pc_we  = 1'b0;
            bus.fd_we  = 1'b0;
            bus.dx_we  = 1'b0;
            bus.xm_nop = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_wd_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Held at zero while idle so it starts clean on every MD_RUN entry.
      if (r_state == IDLE) r_wd_cnt <= '0;
      else                 r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!bus.pc_we)   r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.fd_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with queued expectations and a negedge monitor.
// Latency: expectations are for the same cycle the inputs are applied.
// Backpressure: n/a.
module tb_hazard_stall_ctrl;

  // Expected output vector: {pc_we, fd_we, dx_we, fd_flush, dx_nop, xm_nop, md_start, md_err}
  localparam logic [7:0] E_DEF   = 8'b111_00000;
  localparam logic [7:0] E_LU    = 8'b001_01000;
  localparam logic [7:0] E_BR    = 8'b111_11000;
  localparam logic [7:0] E_START = 8'b000_00110;
  localparam logic [7:0] E_STALL = 8'b000_00100;
  localparam logic [7:0] E_ERR   = 8'b111_00101;

  typedef struct {
    string       tag;
    logic [7:0]  o;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hazard_stall_ctrl_if bus();

  hazard_stall_ctrl #(
    .MD_WATCHDOG (64),
    .ZERO_REG    (5'd0),
    .STATUS_REG  (5'd30)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned acc_s    = 0;
  int unsigned acc_f    = 0;

  function automatic logic [31:0] rtype(input logic [4:0] alu, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs);
    return {op, rd, rs, 17'd0};
  endfunction

  // Apply one cycle of inputs and queue what the outputs must be during that cycle.
  task automatic step(input string tag, input logic rst, input logic [31:0] fd,
                      input logic [31:0] dx, input logic br, input logic rdy,
                      input logic exc, input logic [7:0] eo);
    exp_t e;
    @(posedge clock);
    #1;
    reset            = rst;
    bus.fd_ir        = fd;
    bus.dx_ir        = dx;
    bus.branch_taken = br;
    bus.md_ready     = rdy;
    bus.md_exception = exc;
    e.tag = tag;
    e.o   = rst ? E_DEF : eo;
`ifdef HAZARD_PERF_EN
    e.sc = acc_s;
    e.fc = acc_f;
`else
    e.sc = 32'd0;
    e.fc = 32'd0;
`endif
    q.push_back(e);
    if (rst) begin
      acc_s = 0;
      acc_f = 0;
    end else begin
      if (!eo[7]) acc_s++;
      if (eo[4])  acc_f++;
    end
  endtask

  exp_t       m_e;
  logic [7:0] m_act;

  always @(negedge clock) begin
    if (q.size() > 0) begin
      m_e   = q.pop_front();
      m_act = {bus.pc_we, bus.fd_we, bus.dx_we, bus.fd_flush,
               bus.dx_nop, bus.xm_nop, bus.md_start, bus.md_err};
      checks++;
      if (m_act !== m_e.o) begin
        failures++;
        $display("FAIL %s outputs got=%b want=%b (pc fd dx flush dxnop xmnop start err)",
                 m_e.tag, m_act, m_e.o);
      end
      checks++;
      if ({bus.stall_cnt, bus.flush_cnt} !== {m_e.sc, m_e.fc}) begin
        failures++;
        $display("FAIL %s counters got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 m_e.tag, bus.stall_cnt, bus.flush_cnt, m_e.sc, m_e.fc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] nop, lw_r5, lw_r0, lw_r30, mul, dv;
    logic [31:0] add_1_5_2, add_1_0_0, add_1_2_5, sw_5_3, sw_1_5, jr_5, bex, bne_5_7, addi_5_3;
    nop       = 32'd0;
    lw_r5     = itype(5'b01000, 5'd5, 5'd3);
    lw_r0     = itype(5'b01000, 5'd0, 5'd3);
    lw_r30    = itype(5'b01000, 5'd30, 5'd3);
    mul       = rtype(5'b00110, 5'd3, 5'd1, 5'd2);
    dv        = rtype(5'b00111, 5'd4, 5'd1, 5'd2);
    add_1_5_2 = rtype(5'b00000, 5'd1, 5'd5, 5'd2);
    add_1_0_0 = rtype(5'b00000, 5'd1, 5'd0, 5'd0);
    add_1_2_5 = rtype(5'b00000, 5'd1, 5'd2, 5'd5);
    sw_5_3    = itype(5'b00111, 5'd5, 5'd3);
    sw_1_5    = itype(5'b00111, 5'd1, 5'd5);
    jr_5      = itype(5'b00100, 5'd5, 5'd0);
    bex       = itype(5'b10110, 5'd0, 5'd0);
    bne_5_7   = itype(5'b00010, 5'd5, 5'd7);
    addi_5_3  = itype(5'b00101, 5'd5, 5'd3);

    reset            = 1'b1;
    bus.fd_ir        = nop;
    bus.dx_ir        = nop;
    bus.branch_taken = 1'b0;
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;

    step("reset",       1'b1, nop, nop, 1'b0, 1'b0, 1'b0, E_DEF);
    step("reset_hold",  1'b1, nop, mul, 1'b0, 1'b0, 1'b0, E_DEF);

    // Load-use detection across source-field variants
    step("lu_add_rs",   1'b0, add_1_5_2, lw_r5,  1'b0, 1'b0, 1'b0, E_LU);
    step("lu_bubble",   1'b0, add_1_5_2, nop,    1'b0, 1'b0, 1'b0, E_DEF);
    step("lu_sw_data",  1'b0, sw_5_3,    lw_r5,  1'b0, 1'b0, 1'b0, E_DEF);
    step("lu_sw_base",  1'b0, sw_1_5,    lw_r5,  1'b0, 1'b0, 1'b0, E_LU);
    step("lu_zero",     1'b0, add_1_0_0, lw_r0,  1'b0, 1'b0, 1'b0, E_DEF);
    step("lu_add_rt",   1'b0, add_1_2_5, lw_r5,  1'b0, 1'b0, 1'b0, E_LU);
    step("lu_jr",       1'b0, jr_5,      lw_r5,  1'b0, 1'b0, 1'b0, E_LU);
    step("lu_bex",      1'b0, bex,       lw_r30, 1'b0, 1'b0, 1'b0, E_LU);
    step("lu_bne_rd",   1'b0, bne_5_7,   lw_r5,  1'b0, 1'b0, 1'b0, E_LU);
    step("lu_addi_rd",  1'b0, addi_5_3,  lw_r5,  1'b0, 1'b0, 1'b0, E_DEF);

    // Branch overrides a simultaneous load-use
    step("br_over_lu",  1'b0, add_1_5_2, lw_r5,  1'b1, 1'b0, 1'b0, E_BR);
    step("after_br",    1'b0, nop,       nop,    1'b0, 1'b0, 1'b0, E_DEF);

    // md_ready while idle has no effect
    step("rdy_idle",    1'b0, nop,       nop,    1'b0, 1'b1, 1'b1, E_DEF);
    step("idle_hold",   1'b0, nop,       nop,    1'b0, 1'b0, 1'b0, E_DEF);

    // mul with release on the 17th cycle after start
    step("mul_start",   1'b0, add_1_5_2, mul,    1'b0, 1'b0, 1'b0, E_START);
    for (int i = 1; i <= 16; i++)
      step("mul_run",   1'b0, add_1_5_2, mul,    1'b0, 1'b0, 1'b0, E_STALL);
    step("mul_release", 1'b0, add_1_5_2, mul,    1'b0, 1'b1, 1'b1, E_DEF);

    // Back-to-back div, never completes: watchdog abort 64 cycles after start
    step("div_start",   1'b0, nop,       dv,     1'b0, 1'b0, 1'b0, E_START);
    for (int i = 1; i <= 63; i++)
      step("div_run",   1'b0, nop,       dv,     1'b0, 1'b0, 1'b0, E_STALL);
    step("div_wd",      1'b0, nop,       dv,     1'b0, 1'b0, 1'b0, E_ERR);
    step("after_wd",    1'b0, nop,       nop,    1'b0, 1'b0, 1'b0, E_DEF);

    // Reset in the 10th MD_RUN cycle
    step("mul2_start",  1'b0, nop,       mul,    1'b0, 1'b0, 1'b0, E_START);
    for (int i = 1; i <= 9; i++)
      step("mul2_run",  1'b0, nop,       mul,    1'b0, 1'b0, 1'b0, E_STALL);
    step("rst_mid",     1'b1, nop,       mul,    1'b0, 1'b0, 1'b0, E_DEF);
    step("post_rst",    1'b0, nop,       nop,    1'b0, 1'b0, 1'b0, E_DEF);
    step("mul3_start",  1'b0, nop,       mul,    1'b0, 1'b0, 1'b0, E_START);
    step("mul3_rel",    1'b0, nop,       mul,    1'b0, 1'b1, 1'b0, E_DEF);
    step("final",       1'b0, nop,       nop,    1'b0, 1'b0, 1'b0, E_DEF);

    @(negedge clock);
    @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Producer-side counterpart to the operand forwarding logic.
- Detects hazards that forwarding cannot resolve:
  - load-use dependencies;
  - multi-cycle mul/div occupancy;
  - taken-branch/jump redirection.
- Drives pipeline-register write enables, NOP injection, flush and the multdiv start handshake.
- Sits beside the F/D, D/X and X/M latches and owns the only sequential hazard state in the core.

Parameters:
- MD_WATCHDOG, 64: max cycles in MD_RUN before forced abort; 0 disables the watchdog.
- ZERO_REG, 5'd0: hardwired-zero register index, never a hazard source.
- STATUS_REG, 5'd30: implicit source register of bex.

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high.
- fd_ir  in  32  instruction in F/D latch.
- dx_ir  in  32  instruction in D/X latch.
- branch_taken  in  1  DX-stage bne/blt taken, or j/jal/jr/bex redirect.
- md_ready  in  1  multdiv result valid (one-cycle pulse).
- md_exception  in  1  multdiv overflow/div-by-0, sampled with md_ready.
- pc_we  out  1  PC write enable.
- fd_we  out  1  F/D latch write enable.
- dx_we  out  1  D/X latch write enable.
- fd_flush  out  1  load NOP into F/D.
- dx_nop  out  1  load NOP into D/X.
- xm_nop  out  1  load NOP into X/M.
- md_start  out  1  one-cycle multdiv start pulse.
- md_err  out  1  one-cycle watchdog abort pulse.
- stall_cnt  out  32  stall-cycle count (perf option).
- flush_cnt  out  32  flush count (perf option).

Behaviour:
- Decode:
  - opcode = ir[31:27]; R-type opcode is 00000; ALU op = ir[6:2].
  - mul is R-type with ALU op 00110; div is R-type with ALU op 00111.
  - lw = 01000, sw = 00111, bne = 00010, blt = 00110, jr = 00100, bex = 10110.
- fd sources:
  - R-type: rs = [21:17], rt = [16:12].
  - sw, bne, blt: rs = [21:17], rd = [26:22].
  - jr: rd = [26:22] only.
  - bex: STATUS_REG only.
  - All other opcodes: rs only.
- load_use = dx is lw AND dx_rd != ZERO_REG AND dx_rd matches an fd source.
  - Exception: the only match is sw's data field [26:22]. That case is resolved by write-memory forwarding and does not stall.
- FSM states:
  - IDLE.
  - MD_RUN.
  - State register resets to IDLE.
- IDLE, dx is mul/div:
  - md_start = 1 for exactly that cycle; next state is MD_RUN.
  - pc_we, fd_we and dx_we are all 0; xm_nop = 1.
- MD_RUN:
  - Same stall outputs as above; md_start = 0.
  - On md_ready, that same cycle: all write enables = 1, xm_nop = 0, next state is IDLE (zero-bubble release).
- Watchdog:
  - 7-bit-or-wider counter, cleared on entry to MD_RUN.
  - When it reaches MD_WATCHDOG without md_ready: md_err pulses, state returns to IDLE, stall is released, xm_nop = 1.
- IDLE, load_use (no mul/div in dx): pc_we = 0, fd_we = 0, dx_nop = 1, dx_we = 1. Exactly one bubble.
- branch_taken:
  - fd_flush = 1 and dx_nop = 1; pc_we = 1.
  - Overrides load_use in the same cycle, since the fd instruction is squashed.
  - Branches never coexist with MD_RUN, because dx holds the mul/div.
- Defaults: all write enables 1, all NOP/flush/pulse outputs 0.
- Reset values:
  - pc_we, fd_we, dx_we = 1.
  - All other outputs = 0.
  - Counters = 0.
- Reset mid-MD_RUN: state goes to IDLE, with no md_start and no md_err.
- md_ready in IDLE is ignored.
- md_exception is passed through to nothing; it is documented only for bench checks.
- Back-to-back mul: second md_start fires in the cycle after release.

Optional Feature:
- HAZARD_PERF_EN.
- When defined:
  - stall_cnt increments each cycle pc_we = 0.
  - flush_cnt increments each cycle fd_flush = 1.
  - Both wrap at 2^32 and clear on reset.
- When undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package cpu_pkg: opcode and ALU-op constants, ZERO_REG/STATUS_REG, FSM state enum {IDLE, MD_RUN}.
- One natural sub-module, src_reg_decode: maps an instruction to its two source indices plus a valid mask, reusable by the forwarding unit.

Test Plan:
- dx = lw r5, fd = add r1,r5,r2 -> pc_we = 0, fd_we = 0, dx_nop = 1 for 1 cycle, then defaults.
- dx = lw r5, fd = sw r5,0(r3) -> no stall. dx = lw r0, fd = add r1,r0,r0 -> no stall.
- dx = mul r3,r1,r2 -> md_start = 1 for 1 cycle, stall held. md_ready on cycle 17 -> release that cycle, state IDLE.
- branch_taken = 1 while load_use is also true -> fd_flush = 1, dx_nop = 1, pc_we = 1; with HAZARD_PERF_EN, flush_cnt goes 0 -> 1.
- mul with md_ready never asserted, MD_WATCHDOG = 64 -> md_err pulses at cycle 64 after start, state IDLE. Reset asserted at cycle 10 of MD_RUN -> IDLE, no md_err.
